// File: rtl/pred_update_queue_if.sv
// Handshake bundle for the predictor update queue: push lanes, drain port,
// bypass lookup and status.
interface pred_update_queue_if #(
  parameter int DEPTH          = 32,
  parameter int PUSH_WIDTH     = 2,
  parameter int INDEX_WIDTH    = 10,
  parameter int DATA_WIDTH     = 2,
  parameter int DROP_CNT_WIDTH = 16
);
  logic                              flush;
  logic [PUSH_WIDTH-1:0]             pushValid;
  logic [PUSH_WIDTH*INDEX_WIDTH-1:0] pushIndex;
  logic [PUSH_WIDTH*DATA_WIDTH-1:0]  pushData;
  logic                              pushReady;
  logic                              drainEnable;
  logic                              writeValid;
  logic [INDEX_WIDTH-1:0]            writeIndex;
  logic [DATA_WIDTH-1:0]             writeData;
  logic [INDEX_WIDTH-1:0]            lookupIndex;
  logic                              lookupHit;
  logic [DATA_WIDTH-1:0]             lookupData;
  logic [$clog2(DEPTH+1)-1:0]        count;
  logic [DROP_CNT_WIDTH-1:0]         dropCount;

  modport master (
    output flush, pushValid, pushIndex, pushData, drainEnable, lookupIndex,
    input  pushReady, writeValid, writeIndex, writeData, lookupHit, lookupData,
           count, dropCount
  );

  modport slave (
    input  flush, pushValid, pushIndex, pushData, drainEnable, lookupIndex,
    output pushReady, writeValid, writeIndex, writeData, lookupHit, lookupData,
           count, dropCount
  );
endinterface

// File: rtl/pred_update_queue.sv
// Multi-lane circular update queue feeding a single-ported predictor table,
// with youngest-match bypass lookup and a saturating drop counter.
module pred_update_queue #(
  parameter int DEPTH          = 32,
  parameter int PUSH_WIDTH     = 2,
  parameter int INDEX_WIDTH    = 10,
  parameter int DATA_WIDTH     = 2,
  parameter int DROP_CNT_WIDTH = 16
) (
  input logic              clk,
  input logic              rst,
  pred_update_queue_if.slave bus
);
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int PCW = $clog2(PUSH_WIDTH + 1);

  logic [INDEX_WIDTH-1:0]    mem_index [DEPTH];
  logic [DATA_WIDTH-1:0]     mem_data  [DEPTH];
  logic [AW-1:0]             head;
  logic [AW-1:0]             tail;
  logic [CW-1:0]             count_q;
  logic [DROP_CNT_WIDTH-1:0] drop_q;

  logic [PCW-1:0]            push_cnt;
  logic [AW-1:0]             lane_slot [PUSH_WIDTH];
  logic [CW:0]               free_slots;
  logic                      push_ready;
  logic                      accept;
  logic                      drop;
  logic                      occupied;
  logic                      pop;
  logic [CW-1:0]             acc_cnt;
  logic [DROP_CNT_WIDTH:0]   drop_sum;
  logic                      hit;
  logic [DATA_WIDTH-1:0]     hit_data;

  // Valid lanes are packed densely from tail; each lane's slot is tail plus
  // the number of valid lanes below it.
  always_comb begin
    logic [PCW-1:0] offs;
    offs = '0;
    for (int i = 0; i < PUSH_WIDTH; i++) begin
      lane_slot[i] = tail + AW'(offs);
      if (bus.pushValid[i]) offs = offs + PCW'(1);
    end
    push_cnt = offs;
  end

  assign free_slots = (CW+1)'(DEPTH) - {1'b0, count_q};
  assign push_ready = free_slots >= (CW+1)'(PUSH_WIDTH);
  assign accept     = push_ready & ~bus.flush;
  assign drop       = ~push_ready & ~bus.flush & (|bus.pushValid);
  assign occupied   = (count_q != '0);
  assign pop        = bus.drainEnable & occupied & ~bus.flush;
  assign acc_cnt    = accept ? CW'(push_cnt) : '0;
  assign drop_sum   = {1'b0, drop_q} + (DROP_CNT_WIDTH+1)'(push_cnt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else if (bus.flush) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (pop)    head <= head + AW'(1);
      if (accept) tail <= tail + AW'(push_cnt);
      count_q <= count_q + acc_cnt - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_q <= '0;
    end else if (drop) begin
      drop_q <= drop_sum[DROP_CNT_WIDTH] ? '1 : drop_sum[DROP_CNT_WIDTH-1:0];
    end
  end

  // Entry storage is deliberately left unreset; occupancy alone qualifies it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < PUSH_WIDTH; i++) begin
      if (accept && bus.pushValid[i]) begin
        mem_index[lane_slot[i]] <= bus.pushIndex[i*INDEX_WIDTH +: INDEX_WIDTH];
        mem_data[lane_slot[i]]  <= bus.pushData[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Walk oldest to youngest so the last match seen wins.
  always_comb begin
    logic [AW-1:0] slot;
    hit      = 1'b0;
    hit_data = '0;
    slot     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = head + AW'(k);
      if ((CW'(k) < count_q) && (mem_index[slot] == bus.lookupIndex)) begin
        hit      = 1'b1;
        hit_data = mem_data[slot];
      end
    end
  end

  assign bus.pushReady  = push_ready;
  assign bus.writeValid = pop;
  assign bus.writeIndex = occupied ? mem_index[head] : '0;
  assign bus.writeData  = occupied ? mem_data[head] : '0;
  assign bus.lookupHit  = hit;
  assign bus.lookupData = hit_data;
  assign bus.count      = count_q;
  assign bus.dropCount  = drop_q;
endmodule

// File: tb/tb_pred_update_queue.sv
// Bench for pred_update_queue at DEPTH=4, PUSH_WIDTH=2 against a queue-based
// behavioural model.
module tb_pred_update_queue;
  localparam int DEPTH = 4;
  localparam int PW    = 2;
  localparam int IW    = 10;
  localparam int DW    = 2;
  localparam int XW    = 16;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [DW-1:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pred_update_queue_if #(.DEPTH(DEPTH), .PUSH_WIDTH(PW), .INDEX_WIDTH(IW),
                         .DATA_WIDTH(DW), .DROP_CNT_WIDTH(XW)) bus ();

  pred_update_queue #(.DEPTH(DEPTH), .PUSH_WIDTH(PW), .INDEX_WIDTH(IW),
                      .DATA_WIDTH(DW), .DROP_CNT_WIDTH(XW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  ent_t        q[$];
  int          drops;
  int          tests;
  int          fails;
  logic [35:0] obs_all;
  logic [35:0] exp_all;

  // Drives one cycle, samples outputs mid-cycle, predicts them from the
  // model, then advances the model across the edge.
  task automatic apply(input bit fl, input bit [1:0] pv,
                       input bit [IW-1:0] i0, input bit [DW-1:0] d0,
                       input bit [IW-1:0] i1, input bit [DW-1:0] d1,
                       input bit dr, input bit [IW-1:0] lk);
    bit            ready, wv, hit;
    bit [IW-1:0]   widx;
    bit [DW-1:0]   wd, ld;
    ent_t          e;
    @(negedge clk);
    bus.flush       = fl;
    bus.pushValid   = pv;
    bus.pushIndex   = {i1, i0};
    bus.pushData    = {d1, d0};
    bus.drainEnable = dr;
    bus.lookupIndex = lk;
    #2;
    ready = (DEPTH - q.size()) >= PW;
    wv    = dr && (q.size() != 0) && !fl;
    widx  = (q.size() != 0) ? q[0].idx : '0;
    wd    = (q.size() != 0) ? q[0].data : '0;
    hit   = 1'b0;
    ld    = '0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (!hit && q[i].idx == lk) begin
        hit = 1'b1;
        ld  = q[i].data;
      end
    end
    exp_all = {ready, wv, widx, wd, hit, ld, 3'(q.size()), 16'(drops)};
    obs_all = {bus.pushReady, bus.writeValid, bus.writeIndex, bus.writeData,
               bus.lookupHit, bus.lookupData, bus.count, bus.dropCount};
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (wv) void'(q.pop_front());
      if (ready) begin
        if (pv[0]) begin e.idx = i0; e.data = d0; q.push_back(e); end
        if (pv[1]) begin e.idx = i1; e.data = d1; q.push_back(e); end
      end else begin
        drops = drops + int'(pv[0]) + int'(pv[1]);
        if (drops > 65535) drops = 65535;
      end
    end
  endtask

  task automatic idle_drain();
    for (int g = 0; g < 10 && q.size() != 0; g++) apply(0, 2'b00, 0, 0, 0, 0, 1, 0);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.flush = 0; bus.pushValid = 0; bus.pushIndex = 0; bus.pushData = 0;
    bus.drainEnable = 1; bus.lookupIndex = 0;
    #3;
    tests++;
    if (bus.pushReady !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", bus.pushReady); end
    tests++;
    if (bus.writeValid !== 1'b0) begin fails++; $display("FAIL reset_wv: got %b want 0", bus.writeValid); end
    tests++;
    if ({bus.lookupHit, bus.lookupData} !== 3'b000) begin fails++; $display("FAIL reset_lookup: got %b/%h want 0/0", bus.lookupHit, bus.lookupData); end
    tests++;
    if ({bus.count, bus.dropCount} !== 19'd0) begin fails++; $display("FAIL reset_counts: got %0d/%0d want 0/0", bus.count, bus.dropCount); end
    @(negedge clk);
    rst = 1'b1;
    q.delete();
    drops = 0;
  endtask

  task automatic test_basic();
    apply(0, 2'b11, 5, 1, 9, 3, 0, 0);
    apply(0, 2'b00, 0, 0, 0, 0, 1, 0);
    tests++;
    if (obs_all !== exp_all) begin fails++; $display("FAIL basic_first: got %h want %h", obs_all, exp_all); end
    tests++;
    if ({bus.count, bus.pushReady, bus.writeIndex, bus.writeData} !== {3'd2, 1'b1, 10'd5, 2'd1})
      begin fails++; $display("FAIL basic_pop1: got %0d/%b/%0d/%0d want 2/1/5/1", bus.count, bus.pushReady, bus.writeIndex, bus.writeData); end
    apply(0, 2'b00, 0, 0, 0, 0, 1, 0);
    tests++;
    if (obs_all !== exp_all || bus.writeIndex !== 10'd9) begin fails++; $display("FAIL basic_pop2: got %h want %h", obs_all, exp_all); end
    apply(0, 2'b00, 0, 0, 0, 0, 1, 0);
    tests++;
    if (obs_all !== exp_all || bus.count !== 3'd0) begin fails++; $display("FAIL basic_empty: got %h want %h", obs_all, exp_all); end
  endtask

  task automatic test_lane1_only();
    apply(0, 2'b10, 0, 0, 7, 2, 0, 0);
    apply(0, 2'b00, 0, 0, 0, 0, 1, 7);
    tests++;
    if (obs_all !== exp_all || {bus.writeIndex, bus.writeData} !== {10'd7, 2'd2})
      begin fails++; $display("FAIL lane1_only: got %h want %h", obs_all, exp_all); end
    idle_drain();
  endtask

  task automatic test_lookup();
    apply(0, 2'b01, 4, 1, 0, 0, 0, 4);
    apply(0, 2'b01, 4, 3, 0, 0, 0, 4);
    apply(0, 2'b00, 0, 0, 0, 0, 0, 4);
    tests++;
    if (obs_all !== exp_all || {bus.lookupHit, bus.lookupData} !== 3'b111)
      begin fails++; $display("FAIL lookup_young: got %h want %h", obs_all, exp_all); end
    apply(0, 2'b00, 0, 0, 0, 0, 0, 6);
    tests++;
    if (obs_all !== exp_all || {bus.lookupHit, bus.lookupData} !== 3'b000)
      begin fails++; $display("FAIL lookup_miss: got %h want %h", obs_all, exp_all); end
    apply(0, 2'b00, 0, 0, 0, 0, 1, 4);
    tests++;
    if (obs_all !== exp_all) begin fails++; $display("FAIL lookup_popping: got %h want %h", obs_all, exp_all); end
    idle_drain();
  endtask

  task automatic test_drop();
    apply(0, 2'b11, 11, 1, 12, 2, 0, 0);
    apply(0, 2'b01, 13, 3, 0, 0, 0, 0);
    apply(0, 2'b11, 14, 0, 15, 1, 0, 0);
    tests++;
    if (obs_all !== exp_all || bus.pushReady !== 1'b0) begin fails++; $display("FAIL drop_ready: got %h want %h", obs_all, exp_all); end
    #1;
    tests++;
    if ({bus.count, bus.dropCount} !== {3'd3, 16'd2}) begin fails++; $display("FAIL drop_count: got %0d/%0d want 3/2", bus.count, bus.dropCount); end
    idle_drain();
  endtask

  task automatic test_wrap();
    for (int n = 0; n < 10; n++) begin
      apply(0, 2'b01, IW'(20 + n), DW'(n), 0, 0, 1, IW'(19 + n));
      tests++;
      if (obs_all !== exp_all || bus.count > 3'd1) begin fails++; $display("FAIL wrap_%0d: got %h want %h", n, obs_all, exp_all); end
    end
    idle_drain();
  endtask

  task automatic test_flush();
    apply(0, 2'b11, 30, 1, 31, 2, 0, 0);
    apply(0, 2'b01, 32, 3, 0, 0, 0, 0);
    apply(1, 2'b11, 33, 0, 34, 1, 1, 30);
    tests++;
    if (obs_all !== exp_all || bus.writeValid !== 1'b0) begin fails++; $display("FAIL flush_cycle: got %h want %h", obs_all, exp_all); end
    apply(0, 2'b00, 0, 0, 0, 0, 1, 33);
    tests++;
    if (obs_all !== exp_all || {bus.count, bus.dropCount} !== {3'd0, 16'd2})
      begin fails++; $display("FAIL flush_after: got %h want %h", obs_all, exp_all); end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int n = 0; n < 400; n++) begin
      apply($urandom_range(0, 19) == 0, 2'($urandom),
            IW'($urandom_range(0, 7)), DW'($urandom), IW'($urandom_range(0, 7)), DW'($urandom),
            $urandom_range(0, 1) == 1, IW'($urandom_range(0, 7)));
      tests++;
      if (obs_all !== exp_all) begin
        fails++;
        if (bad < 8) $display("FAIL random_%0d: got %h want %h", n, obs_all, exp_all);
        bad++;
      end
    end
    idle_drain();
  endtask

  task automatic test_saturate();
    apply(0, 2'b11, 1, 1, 2, 2, 0, 0);
    apply(0, 2'b11, 3, 3, 4, 0, 0, 0);
    for (int n = 0; n < 32771; n++) apply(0, 2'b11, 5, 1, 6, 2, 0, 0);
    apply(0, 2'b11, 5, 1, 6, 2, 0, 0);
    tests++;
    if (obs_all !== exp_all || bus.dropCount !== 16'hFFFF) begin fails++; $display("FAIL saturate: got %h want %h", obs_all, exp_all); end
    idle_drain();
  endtask

  task automatic test_async_reset();
    apply(0, 2'b11, 40, 1, 41, 2, 0, 0);
    apply(0, 2'b00, 0, 0, 0, 0, 1, 0);
    #2;
    rst = 1'b0;
    #1;
    tests++;
    if (bus.writeValid !== 1'b0) begin fails++; $display("FAIL async_wv: got %b want 0", bus.writeValid); end
    tests++;
    if ({bus.count, bus.dropCount, bus.lookupHit} !== 20'd0) begin fails++; $display("FAIL async_state: got %0d/%0d/%b want 0/0/0", bus.count, bus.dropCount, bus.lookupHit); end
    q.delete();
    drops = 0;
    @(negedge clk);
    rst = 1'b1;
    apply(0, 2'b00, 0, 0, 0, 0, 1, 40);
    tests++;
    if (obs_all !== exp_all) begin fails++; $display("FAIL async_after: got %h want %h", obs_all, exp_all); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    drops = 0;
    test_reset();
    test_basic();
    test_lane1_only();
    test_lookup();
    test_drop();
    test_wrap();
    test_flush();
    test_random();
    test_saturate();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
